eae_seq: RTL and testbench
==========================

# eae_seq

Parametrised, iterative Extended Arithmetic Element (EAE) sequencer for the PDP-8 core. It implements multiply-add, divide with overflow detection, left/right shifts and normalize on an {AC,MQ} double word of configurable width. It uses a one-bit-per-cycle datapath, a step counter and a start/busy/done handshake. The CPU instruction decoder drives it and takes results back on the `done` pulse.

## Interface
- `WORD_W`, 12: width of AC, MQ and operand.
- `SC_W`, 5: step-counter width; must satisfy 2^SC_W ≥ 2·WORD_W.
- `clock` in 1: single clock, rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `start` in 1: operation request; sampled only in IDLE.
- `op` in 3: `eae_op_t` opcode.
- `ac_in`, `mq_in` in WORD_W: initial AC and MQ.
- `operand` in WORD_W: multiplicand, divisor, or shift count in bits [SC_W-1:0].
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle completion pulse.
- `ac_out`, `mq_out` out WORD_W: working AC and MQ.
- `link_out` out 1: link result.
- `sc_out` out SC_W: step-counter result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE→RUN or DONE: on an edge with `start`=1, load ac/mq/operand/op and set the step count N per op.
  - If N=0, go directly to DONE.
- RUN: each edge performs one step and decrements the counter. Go to DONE on the edge that performs the last step.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored.
- NOP (0) and reserved (7): N=0; outputs equal the loaded values; link=0; sc=0.
- MUY (1): {AC,MQ} = MQ·operand + AC, unsigned, shift-add, N=WORD_W. The sum always fits in 2·WORD_W bits. link=0, sc=0.
- DVI (2): {AC,MQ} ÷ operand, restoring, N=WORD_W. Result MQ=quotient, AC=remainder, link=0.
  - If AC ≥ operand (including operand=0): overflow. N=0, AC/MQ unchanged, link=1.
- SHL (3): N=operand[SC_W-1:0]+1. Each step shifts {link,AC,MQ} left; the bit leaving AC[msb] enters link, zero enters MQ[0].
- ASR (4): N=operand[SC_W-1:0]+1. Each step shifts right, AC[msb] is replicated, MQ[0] enters link.
- LSR (5): same as ASR but zero-filled.
- For SHL/ASR/LSR: sc=0 at completion; excess shifts past 2·WORD_W continue the same rule.
- NMI (6): shift {AC,MQ} left until AC[msb]≠AC[msb-1], or {AC,MQ}=0, or {AC,MQ}=100…0.
  - N equals the number of shifts, 0..2·WORD_W-1; the termination test happens before each step.
  - sc = shifts performed; link=0.
- Outputs track the working registers. They are valid from the `done` cycle until the next accepted `start`.

## Timing
- `start` accepted at edge k: `done` is high in the cycle after edge k+N. Latency is N+1 cycles from acceptance.
- Fixed latency: MUY/DVI = WORD_W+1; DVI overflow and NOP = 1.
- Back-to-back operation: `start` may be reasserted in the cycle after `done` (IDLE).
- Reset, including mid-operation: state IDLE. `busy`, `done`, `link_out` = 0; `ac_out`, `mq_out`, `sc_out` = 0. No `done` is issued for the aborted operation.

## Structure
- Shared package `CPU_Definitions.pkg` holds:
  - `eae_op_t`, with encodings 0..7 as above.
  - the `eae_state_t` enum.
  - default widths as localparams.
- Natural sub-module: `eae_datapath`, containing the AC/MQ/link shift-add/subtract step logic.
- `eae_seq` keeps the FSM and step counter.

## Test plan
- MUY, AC=0x005, MQ=0x123, operand=0x010 → `done` at cycle 13; AC=0x001, MQ=0x235, link=0.
- DVI, AC=0x001, MQ=0x000, operand=0x010 → MQ=0x100, AC=0x000, link=0, latency 13.
- DVI overflow, AC=0x020, MQ=0x555, operand=0x010 → `done` after 1 cycle; link=1, AC=0x020, MQ=0x555 unchanged.
- NMI, AC=0x001, MQ=0x000 → AC=0x400, MQ=0x000, sc=10, latency 11.
  - NMI with AC=0x000, MQ=0x000 → sc=0, latency 1.
- ASR, AC=0x800, MQ=0x001, operand=0 → AC=0xC00, MQ=0x000, link=1.
  - LSR with the same inputs → AC=0x400.
- Assert `resetN`=0 mid-MUY at RUN cycle 5 → all outputs 0, no `done`.
  - After release, a new MUY completes correctly.
  - A `start` pulse during `busy` is ignored.

Source files
------------

// File: rtl/eae_seq_pkg.sv
// eae_seq_pkg: opcodes, sequencer states and default widths shared by the EAE sequencer.
package eae_seq_pkg;
    localparam int DEF_WORD_W = 12;
    localparam int DEF_SC_W   = 5;
    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_MUY = 3'd1,
        OP_DVI = 3'd2,
        OP_SHL = 3'd3,
        OP_ASR = 3'd4,
        OP_LSR = 3'd5,
        OP_NMI = 3'd6,
        OP_RSV = 3'd7
    } eae_op_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } eae_state_t;
endpackage

// File: rtl/eae_seq_datapath.sv
// eae_datapath: AC/MQ/link registers and the one-bit-per-cycle step logic
// (shift-add multiply, restoring divide, shifts, normalize).
module eae_datapath
    import eae_seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [2:0]        i_ld_op,
    input  logic [2:0]        i_run_op,
    input  logic [WORD_W-1:0] i_ac,
    input  logic [WORD_W-1:0] i_mq,
    input  logic [WORD_W-1:0] i_operand,
    output logic [WORD_W-1:0] o_ac,
    output logic [WORD_W-1:0] o_mq,
    output logic              o_link,
    output logic              o_ovf,
    output logic              o_norm_in,
    output logic              o_norm_next
);
    logic [WORD_W-1:0] r_ac, r_mq, r_d;
    logic              r_link;
    logic [WORD_W:0]   w_sum, w_rem, w_diff;
    logic              w_ge, w_link;
    logic [WORD_W-1:0] w_ac, w_mq;

    // 100...0 already has msb != msb-1, so it needs no separate test
    function automatic logic is_norm(input logic [2*WORD_W-1:0] v);
        return (v[2*WORD_W-1] != v[2*WORD_W-2]) || (v == '0);
    endfunction

    always_comb begin
        w_sum  = {1'b0, r_ac} + {1'b0, (r_mq[0] ? r_d : {WORD_W{1'b0}})};
        w_rem  = {r_ac, r_mq[WORD_W-1]};
        w_diff = w_rem - {1'b0, r_d};
        w_ge   = w_rem >= {1'b0, r_d};
        w_ac   = r_ac;
        w_mq   = r_mq;
        w_link = r_link;
        case (i_run_op)
            OP_MUY: {w_ac, w_mq} = {w_sum, r_mq[WORD_W-1:1]};
            OP_DVI: begin
                w_ac = w_ge ? w_diff[WORD_W-1:0] : w_rem[WORD_W-1:0];
                w_mq = {r_mq[WORD_W-2:0], w_ge};
            end
            OP_SHL: {w_link, w_ac, w_mq} = {r_ac, r_mq, 1'b0};
            OP_ASR: {w_ac, w_mq, w_link} = {r_ac[WORD_W-1], r_ac, r_mq};
            OP_LSR: {w_ac, w_mq, w_link} = {1'b0, r_ac, r_mq};
            OP_NMI: {w_ac, w_mq} = {r_ac[WORD_W-2:0], r_mq, 1'b0};
            default: ;
        endcase
    end

    assign o_ovf       = i_ac >= i_operand;
    assign o_norm_in   = is_norm({i_ac, i_mq});
    assign o_norm_next = is_norm({w_ac, w_mq});
    assign o_ac        = r_ac;
    assign o_mq        = r_mq;
    assign o_link      = r_link;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_ac   <= '0;
            r_mq   <= '0;
            r_d    <= '0;
            r_link <= 1'b0;
        end else if (i_load) begin
            r_ac   <= i_ac;
            r_mq   <= i_mq;
            r_d    <= i_operand;
            r_link <= (i_ld_op == OP_DVI) && o_ovf;
        end else if (i_step) begin
            r_ac   <= w_ac;
            r_mq   <= w_mq;
            r_link <= w_link;
        end
    end
endmodule

// File: rtl/eae_seq.sv
// eae_seq: EAE sequencer FSM and step counter around eae_datapath,
// with a start/busy/done handshake toward the instruction decoder.
module eae_seq
    import eae_seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int SC_W   = DEF_SC_W
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WORD_W-1:0] ac_in,
    input  logic [WORD_W-1:0] mq_in,
    input  logic [WORD_W-1:0] operand,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] ac_out,
    output logic [WORD_W-1:0] mq_out,
    output logic              link_out,
    output logic [SC_W-1:0]   sc_out
);
    localparam logic [SC_W:0] CNT_ONE  = {{SC_W{1'b0}}, 1'b1};
    localparam logic [SC_W:0] CNT_WORD = (SC_W+1)'(WORD_W);

    eae_state_t      r_state;
    logic [2:0]      r_op;
    logic [SC_W:0]   r_cnt, w_n;
    logic [SC_W-1:0] r_sc;
    logic            w_load, w_step, w_last, w_ovf, w_norm_in, w_norm_next;

    // NMI has no precomputed count: it runs until the next value is normalized
    always_comb begin
        w_load = (r_state == ST_IDLE) && start;
        w_step = r_state == ST_RUN;
        w_last = (r_op == OP_NMI) ? w_norm_next : (r_cnt == CNT_ONE);
        w_n    = '0;
        case (op)
            OP_MUY:                 w_n = CNT_WORD;
            OP_DVI:                 w_n = w_ovf ? '0 : CNT_WORD;
            OP_SHL, OP_ASR, OP_LSR: w_n = {1'b0, operand[SC_W-1:0]} + CNT_ONE;
            OP_NMI:                 w_n = w_norm_in ? '0 : CNT_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_sc    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= (w_n == '0) ? ST_DONE : ST_RUN;
                    r_op    <= op;
                    r_cnt   <= w_n;
                    r_sc    <= '0;
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    r_sc  <= (r_op == OP_NMI) ? r_sc + CNT_ONE[SC_W-1:0] : r_sc;
                    if (w_last) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = r_state != ST_IDLE;
    assign done   = r_state == ST_DONE;
    assign sc_out = r_sc;

    eae_datapath #(.WORD_W(WORD_W)) u_dp (
        .clock      (clock),
        .resetN     (resetN),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_ld_op    (op),
        .i_run_op   (r_op),
        .i_ac       (ac_in),
        .i_mq       (mq_in),
        .i_operand  (operand),
        .o_ac       (ac_out),
        .o_mq       (mq_out),
        .o_link     (link_out),
        .o_ovf      (w_ovf),
        .o_norm_in  (w_norm_in),
        .o_norm_next(w_norm_next)
    );
endmodule

// File: tb/tb_eae_seq.sv
// tb_eae_seq: table vectors, randomized ops against an arithmetic reference
// model, and hand-written reset-abort / busy-start sequences for eae_seq.
module tb_eae_seq;
    localparam int     W    = 12;
    localparam int     DW   = 24;
    localparam longint MSK  = 64'hFFF;
    localparam longint DMSK = 64'hFF_FFFF;
    localparam longint SIGN = 64'h80_0000;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] ac, mq, opd;
        longint      eac, emq, el, es, elat;
    } vec_t;

    logic        clock = 1'b0, resetN = 1'b0, start = 1'b0;
    logic [2:0]  op = '0;
    logic [11:0] ac_in = '0, mq_in = '0, operand = '0;
    logic        busy, done, link_out;
    logic [11:0] ac_out, mq_out;
    logic [4:0]  sc_out;
    int          checks = 0, errors = 0;
    vec_t        tbl[17];

    eae_seq #(.WORD_W(W), .SC_W(5)) dut (
        .clock(clock), .resetN(resetN), .start(start), .op(op),
        .ac_in(ac_in), .mq_in(mq_in), .operand(operand),
        .busy(busy), .done(done), .ac_out(ac_out), .mq_out(mq_out),
        .link_out(link_out), .sc_out(sc_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: {AC,MQ} treated as one 24-bit number, results from plain arithmetic
    function automatic void model(input int o, input longint a, m, d,
                                  output longint ea, em, el, es, elat);
        longint v, t, sv;
        int n;
        v = (a << W) | m;
        ea = a; em = m; el = 0; es = 0; elat = 1;
        case (o)
            1: begin t = m * d + a; ea = t >> W; em = t & MSK; elat = W + 1; end
            2: if (a >= d) el = 1;
               else begin ea = v % d; em = v / d; elat = W + 1; end
            3, 4, 5: begin
                n    = int'(d & 31) + 1;
                elat = n + 1;
                sv   = (o == 4) ? ((v ^ SIGN) - SIGN) : v;
                t    = (o == 3) ? (v << n) : (sv >>> n);
                el   = (o == 3) ? ((t >> DW) & 1) : ((sv >>> (n - 1)) & 1);
                ea   = (t >> W) & MSK;
                em   = t & MSK;
            end
            6: begin
                while (((v >> 23) & 1) == ((v >> 22) & 1) && v != 0) begin
                    v = (v << 1) & DMSK;
                    es++;
                end
                ea = v >> W; em = v & MSK; elat = es + 1;
            end
            default: ;
        endcase
    endfunction

    // Caller is at a negedge; returns at the negedge after the done cycle (IDLE)
    task automatic exec(input string nm, input logic [2:0] o, input logic [11:0] a, m, d,
                        input int inj, input longint ea, em, el, es, elat);
        int lat;
        op = o; ac_in = a; mq_in = m; operand = d; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            start = (lat == inj);
            if (lat == inj) begin op = 3'd1; ac_in = '1; mq_in = '1; operand = '1; end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        chk({nm, "_ac"}, ac_out, ea);
        chk({nm, "_mq"}, mq_out, em);
        chk({nm, "_link"}, link_out, el);
        chk({nm, "_sc"}, sc_out, es);
        chk({nm, "_latency"}, lat, elat);
        @(negedge clock);
        chk({nm, "_done_pulse"}, {busy, done}, 0);
    endtask

    initial begin
        int     o, seen;
        longint a, m, d, ea, em, el, es, elat;
        tbl[0]  = '{3'd1, 12'h005, 12'h123, 12'h010, 'h001, 'h235, 0, 0, 13};
        tbl[1]  = '{3'd2, 12'h001, 12'h000, 12'h010, 'h000, 'h100, 0, 0, 13};
        tbl[2]  = '{3'd2, 12'h020, 12'h555, 12'h010, 'h020, 'h555, 1, 0, 1};
        tbl[3]  = '{3'd6, 12'h001, 12'h000, 12'h000, 'h400, 'h000, 0, 10, 11};
        tbl[4]  = '{3'd6, 12'h000, 12'h000, 12'h000, 'h000, 'h000, 0, 0, 1};
        tbl[5]  = '{3'd4, 12'h800, 12'h001, 12'h000, 'hC00, 'h000, 1, 0, 2};
        tbl[6]  = '{3'd5, 12'h800, 12'h001, 12'h000, 'h400, 'h000, 1, 0, 2};
        tbl[7]  = '{3'd0, 12'h123, 12'h456, 12'hFFF, 'h123, 'h456, 0, 0, 1};
        tbl[8]  = '{3'd7, 12'hABC, 12'hDEF, 12'h001, 'hABC, 'hDEF, 0, 0, 1};
        tbl[9]  = '{3'd3, 12'h800, 12'h001, 12'h000, 'h000, 'h002, 1, 0, 2};
        tbl[10] = '{3'd3, 12'h123, 12'h456, 12'h01F, 'h000, 'h000, 0, 0, 33};
        tbl[11] = '{3'd6, 12'hFFF, 12'hFFF, 12'h000, 'h800, 'h000, 0, 23, 24};
        tbl[12] = '{3'd2, 12'h000, 12'h000, 12'h000, 'h000, 'h000, 1, 0, 1};
        tbl[13] = '{3'd1, 12'hFFF, 12'hFFF, 12'hFFF, 'hFFF, 'h000, 0, 0, 13};
        tbl[14] = '{3'd4, 12'h800, 12'h000, 12'h01F, 'hFFF, 'hFFF, 1, 0, 33};
        tbl[15] = '{3'd6, 12'h800, 12'h000, 12'h000, 'h800, 'h000, 0, 0, 1};
        tbl[16] = '{3'd2, 12'h00A, 12'h123, 12'h01B, 'h016, 'h5F7, 0, 0, 13};

        #1 chk("reset_outputs", {busy, done, link_out, ac_out, mq_out, sc_out}, 0);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 17; i++)
            exec($sformatf("vec%0d", i), tbl[i].op, tbl[i].ac, tbl[i].mq, tbl[i].opd, 0,
                 tbl[i].eac, tbl[i].emq, tbl[i].el, tbl[i].es, tbl[i].elat);

        for (int i = 0; i < 40; i++) begin
            o = int'($urandom_range(0, 7));
            a = longint'($urandom_range(0, 4095));
            m = longint'($urandom_range(0, 4095));
            d = longint'($urandom_range(0, 4095));
            if (o == 2 && d != 0 && $urandom_range(0, 3) != 0) a = a % d;
            model(o, a, m, d, ea, em, el, es, elat);
            exec($sformatf("rnd%0d_op%0d", i, o), 3'(o), 12'(a), 12'(m), 12'(d), 0,
                 ea, em, el, es, elat);
        end

        // abort a MUY partway through RUN
        op = 3'd1; ac_in = 12'h005; mq_in = 12'h123; operand = 12'h010; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("abort_busy_before", busy, 1);
        resetN = 1'b0;
        #1 chk("abort_outputs", {busy, done, link_out, ac_out, mq_out, sc_out}, 0);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            seen += int'(done | busy);
        end
        chk("abort_no_done", seen, 0);
        exec("after_abort", 3'd1, 12'h005, 12'h123, 12'h010, 0, 'h001, 'h235, 0, 0, 13);

        exec("busy_start", 3'd1, 12'h005, 12'h123, 12'h010, 3, 'h001, 'h235, 0, 0, 13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
